// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage register.
// State encoding and default widths used by pipe_skid_reg and its counters.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 96;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter used for the stage's stall/drop statistics.
// Adds 0..3 per enabled cycle and sticks at the all-ones value.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_en,
  input  logic [1:0]   inc_amt,
  output logic [W-1:0] value
);

  logic [W:0]   sum;
  logic [W-1:0] value_d;

  // One extra bit catches overflow; W >= 2 keeps a +3 step within W+1 bits.
  assign sum     = {1'b0, value} + (W+1)'(inc_amt);
  assign value_d = sum[W] ? {W{1'b1}} : sum[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (inc_en) begin
      value <= value_d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and saturating stall/drop statistics.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_acc_c, out_acc_c;
  logic [1:0]        held_c;
  logic [1:0]        drop_amt_c;
  logic              stall_c;

  // Handshakes only see flop-driven ready/valid, so no comb path crosses the stage.
  assign in_acc_c  = in_valid & in_ready;
  assign out_acc_c = out_valid & out_ready;
  assign stall_c   = out_valid & ~out_ready;
  assign out_data  = main_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      out_valid <= (state_d != ST_EMPTY);
      in_ready  <= (state_d != ST_TWO);
    end
  end

  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    held_c     = 2'd0;
    drop_amt_c = 2'd0;

    unique case (state_q)
      ST_ONE:  held_c = 2'd1;
      ST_TWO:  held_c = 2'd2;
      default: held_c = 2'd0;
    endcase

    if (Flush) begin
      // Result is always 0..2 (in_acc cannot coincide with two held entries).
      drop_amt_c = held_c + 2'(in_acc_c) - 2'(out_acc_c);
      state_d    = ST_EMPTY;
      main_d     = '0;
      skid_d     = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_acc_c) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_acc_c && out_acc_c) begin
            main_d = in_data;
          end else if (in_acc_c) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (out_acc_c) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_acc_c) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .inc_en  (stall_c),
    .inc_amt (2'd1),
    .value   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .inc_en  (Flush),
    .inc_amt (drop_amt_c),
    .value   (drop_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus random traffic, checked
// against a queue-based model of the stage (beats held, flush drops, counters).
module tb_pipe_skid_reg;

  localparam int unsigned DW      = 96;
  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          Flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: ordered list of held beats, value shown when idle, counters.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_idle;
  int            m_stall;
  int            m_drop;

  pipe_skid_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Flush     (Flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 Clk = ~Clk;

  function automatic int sat(input int x);
    return (x > CNT_MAX) ? CNT_MAX : x;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_idle  = '0;
    m_stall = 0;
    m_drop  = 0;
  endtask

  task automatic check_outputs(input string ctx);
    logic          exp_ov;
    logic          exp_ir;
    logic [DW-1:0] exp_d;
    exp_ov = (mq.size() > 0);
    exp_ir = (mq.size() < 2);
    exp_d  = (mq.size() > 0) ? mq[0] : m_idle;
    chk({ctx, ".out_valid"}, DW'(out_valid), DW'(exp_ov));
    chk({ctx, ".in_ready"},  DW'(in_ready),  DW'(exp_ir));
    chk({ctx, ".out_data"},  out_data,       exp_d);
    chk({ctx, ".stall_cnt"}, DW'(stall_cnt), DW'(m_stall));
    chk({ctx, ".drop_cnt"},  DW'(drop_cnt),  DW'(m_drop));
  endtask

  // Check current outputs, advance the model with the applied inputs, then clock.
  task automatic step(input string ctx);
    int            held;
    logic          ia;
    logic          oa;
    logic [DW-1:0] popped;
    check_outputs(ctx);
    held = mq.size();
    ia   = in_valid && (held < 2);
    oa   = (held > 0) && out_ready;
    if (held > 0 && !out_ready) m_stall = sat(m_stall + 1);
    if (Flush) begin
      m_drop = sat(m_drop + held - int'(oa) + int'(ia));
      mq.delete();
      m_idle = '0;
    end else begin
      if (oa) begin
        popped = mq.pop_front();
        if (mq.size() == 0 && !ia) m_idle = popped;
      end
      if (ia) mq.push_back(in_data);
    end
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic idle_inputs();
    Flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset held with random inputs toggling
    Reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      Flush     = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = rand_data();
      @(posedge Clk);
      #1;
    end
    idle_inputs();
    Reset_n = 1'b1;
    check_outputs("reset");
    step("reset_idle");

    // Streaming 1..4 with downstream always ready
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = DW'(i);
      step("stream");
    end
    in_valid = 1'b0;
    chk("stream.last", out_data, DW'(4));
    step("stream_drain");
    step("stream_idle");

    // Back-pressure: A, B fill both entries, C waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'('hA);
    step("bp_a");
    in_data   = DW'('hB);
    step("bp_b");
    chk("bp.full_in_ready", DW'(in_ready), DW'(0));
    in_data   = DW'('hC);
    step("bp_c_held");
    step("bp_c_held2");
    out_ready = 1'b1;
    step("bp_rel_a");
    chk("bp.order_b", out_data, DW'('hB));
    step("bp_rel_b");
    in_valid  = 1'b0;
    chk("bp.order_c", out_data, DW'('hC));
    step("bp_rel_c");
    step("bp_idle");

    // Flush while holding two beats
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'('hA);
    step("fl2_a");
    in_data   = DW'('hB);
    step("fl2_b");
    in_valid  = 1'b0;
    Flush     = 1'b1;
    step("fl2_flush");
    Flush     = 1'b0;
    chk("fl2.out_data_zero", out_data, DW'(0));
    step("fl2_after");

    // Flush with both handshakes in the same cycle
    in_valid  = 1'b1;
    in_data   = DW'('h11);
    step("flhs_load");
    out_ready = 1'b1;
    in_data   = DW'('h22);
    Flush     = 1'b1;
    chk("flhs.main_beat", out_data, DW'('h11));
    step("flhs_flush");
    Flush     = 1'b0;
    in_valid  = 1'b0;
    step("flhs_after");

    // Stall counter saturation
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = rand_data();
    step("sat_load");
    in_valid  = 1'b0;
    for (int i = 0; i < 20; i++) step("sat_hold");
    chk("sat.stall_15", DW'(stall_cnt), DW'(15));

    // Asynchronous reset in the middle of a cycle
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    idle_inputs();
    step("async_rst_rel");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      Flush     = 1'($urandom_range(0, 19) == 0);
      in_data   = rand_data();
      step("rand");
    end
    idle_inputs();
    check_outputs("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
